// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the M-extension multiply/divide sequencer.
// Holds the funct3/funct7 encodings of the RV32M instructions and the state
// encoding of the iterative sequencer FSM.
// No ports: this is a package imported with import riscv_pkg::*.
package riscv_pkg;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_t;

endpackage

// File: rtl/ex_muldiv_ctrl_if.sv
// Handshake between the EX stage and the multiply/divide sequencer.
// Signals:
//   start  - EX holds a valid M-extension instruction
//   funct3 - M operation select
//   op_a   - forwarded rs1 value
//   op_b   - forwarded rs2 value
//   flush  - EX flush, aborts any operation in flight
//   stall  - hold PC, IF/ID, ID/EX and EX/MEM
//   done   - one-cycle pulse, result valid
//   result - operation result, held until the next accepted start
// Modports: master is the pipeline side, slave is the sequencer side.
interface ex_muldiv_ctrl_if #(
    parameter int XLEN = 32
);

    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, op_a, op_b, flush,
        input  stall, done, result
    );

    modport slave (
        input  start, funct3, op_a, op_b, flush,
        output stall, done, result
    );

endinterface

// File: rtl/muldiv_core.sv
// Iteration datapath of the multiply/divide sequencer: one shift-add
// multiply step or one restoring-divide step per clock on operand magnitudes.
// Ports:
//   clk, reset - pipeline clock, asynchronous active-high reset
//   load       - capture magnitudes and clear the accumulator
//   step       - perform one iteration
//   div_mode   - 1 selects the divide step, 0 the multiply step
//   mag_a      - magnitude of rs1 (multiplicand / dividend)
//   mag_b      - magnitude of rs2 (multiplier / divisor)
//   hi_nxt     - upper half after the current step (product high / remainder)
//   lo_nxt     - lower half after the current step (product low / quotient)
module muldiv_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic            div_mode,
    input  logic [XLEN-1:0] mag_a,
    input  logic [XLEN-1:0] mag_b,
    output logic [XLEN-1:0] hi_nxt,
    output logic [XLEN-1:0] lo_nxt
);

    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] op_q;

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN-1:0] div_sub;
    logic            div_fits;

    // Next value of the {hi, lo} pair for one iteration.
    // Multiply: lo holds the multiplier and is shifted out LSB first while the
    // 33-bit partial sum is shifted in from the top, so {hi, lo} ends as the
    // 64-bit product after XLEN steps.
    // Divide: {hi, lo} is shifted left one bit; hi is the partial remainder,
    // lo shifts out the dividend and shifts in quotient bits. When the shifted
    // remainder fits the divisor the subtraction is kept. The subtraction is
    // only used when it fits, so its result never needs the extra top bit.
    always_comb begin
        mul_sum   = lo_q[0] ? ({1'b0, hi_q} + {1'b0, op_q}) : {1'b0, hi_q};
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_sub   = div_shift[XLEN-1:0] - op_q;
        div_fits  = (div_shift >= {1'b0, op_q});
        hi_nxt    = hi_q;
        lo_nxt    = lo_q;
        if (div_mode) begin
            hi_nxt = div_fits ? div_sub : div_shift[XLEN-1:0];
            lo_nxt = {lo_q[XLEN-2:0], div_fits};
        end else begin
            hi_nxt = mul_sum[XLEN:1];
            lo_nxt = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // Operand and accumulator registers. On load the roles are assigned:
    // multiply keeps the multiplicand in op_q and the multiplier in lo_q,
    // divide keeps the divisor in op_q and the dividend in lo_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
            op_q <= '0;
        end else if (load) begin
            hi_q <= '0;
            lo_q <= div_mode ? mag_a : mag_b;
            op_q <= div_mode ? mag_b : mag_a;
        end else if (step) begin
            hi_q <= hi_nxt;
            lo_q <= lo_nxt;
        end
    end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// Iterative RV32M multiply/divide sequencer beside the EX stage ALU.
// Accepts forwarded operands, stalls the front of the pipeline while it
// iterates, then pulses done for one cycle with the 32-bit result.
// Ports:
//   clk, reset - pipeline clock, asynchronous active-high reset
//   bus        - ex_muldiv_ctrl_if slave: start/funct3/op_a/op_b/flush in,
//                stall/done/result out
module ex_muldiv_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    ex_muldiv_ctrl_if.slave     bus
);

    muldiv_state_t    state;
    logic [CNT_W-1:0] count;
    logic [2:0]       f3_q;
    logic             neg_q;
    logic             done_q;
    logic [XLEN-1:0]  result_q;

    logic             accept;
    logic             a_neg;
    logic             b_neg;
    logic             neg_res;
    logic             div_zero;
    logic             overflow;
    logic             special;
    logic [XLEN-1:0]  mag_a;
    logic [XLEN-1:0]  mag_b;
    logic [XLEN-1:0]  special_val;
    logic             core_load;
    logic             core_step;
    logic             core_div;
    logic             last_step;
    logic [XLEN-1:0]  hi_nxt;
    logic [XLEN-1:0]  lo_nxt;
    logic [2*XLEN-1:0] prod_full;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]  quo_fix;
    logic [XLEN-1:0]  rem_fix;
    logic [XLEN-1:0]  final_val;

    // Accept decode. Operands are turned into magnitudes here so the core only
    // does unsigned work; neg_res records whether the final value must be
    // negated (quotient/product sign, or the dividend sign for REM).
    // Divide-by-zero and signed overflow skip iteration and go straight to
    // DONE with their architecturally defined values.
    always_comb begin
        accept      = (state == ST_IDLE) && bus.start && !bus.flush;
        a_neg       = bus.op_a[XLEN-1] &&
                      (bus.funct3 != F3_MULHU) && (bus.funct3 != F3_DIVU) &&
                      (bus.funct3 != F3_REMU);
        b_neg       = bus.op_b[XLEN-1] &&
                      ((bus.funct3 == F3_MUL) || (bus.funct3 == F3_MULH) ||
                       (bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM));
        mag_a       = a_neg ? -bus.op_a : bus.op_a;
        mag_b       = b_neg ? -bus.op_b : bus.op_b;
        neg_res     = (bus.funct3 == F3_REM) ? a_neg : (a_neg ^ b_neg);
        div_zero    = bus.funct3[2] && (bus.op_b == '0);
        overflow    = ((bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM)) &&
                      (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (bus.op_b == '1);
        special     = div_zero || overflow;
        special_val = '0;
        if (div_zero) begin
            special_val = bus.funct3[1] ? bus.op_a : '1;
        end else begin
            special_val = bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // Core control. While idle the core is told the mode of the incoming op so
    // the load routes operands correctly; afterwards the mode follows the state.
    // A flush stops stepping in the same cycle it aborts the op.
    always_comb begin
        core_load = accept && !special;
        core_step = ((state == ST_MUL) || (state == ST_DIV)) && !bus.flush;
        core_div  = (state == ST_IDLE) ? bus.funct3[2] : (state == ST_DIV);
        last_step = (count == CNT_W'(XLEN-1));
    end

    muldiv_core #(
        .XLEN (XLEN)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (core_load),
        .step     (core_step),
        .div_mode (core_div),
        .mag_a    (mag_a),
        .mag_b    (mag_b),
        .hi_nxt   (hi_nxt),
        .lo_nxt   (lo_nxt)
    );

    // Result formatting from the values the core produces on its final step,
    // so result can be registered on the same edge that enters DONE.
    always_comb begin
        prod_full = {hi_nxt, lo_nxt};
        prod_fix  = neg_q ? -prod_full : prod_full;
        quo_fix   = neg_q ? -lo_nxt : lo_nxt;
        rem_fix   = neg_q ? -hi_nxt : hi_nxt;
        case (f3_q)
            F3_MUL:                       final_val = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: final_val = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              final_val = quo_fix;
            default:                      final_val = rem_fix;
        endcase
    end

    // Sequencer FSM with registered done/result. Flush wins over everything,
    // including the final iteration, so an aborted op never pulses done and
    // never disturbs result. DONE always returns to IDLE without looking at
    // start, so the instruction still sitting in EX is not accepted twice.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            count    <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.flush) begin
                state <= ST_IDLE;
                count <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            f3_q  <= bus.funct3;
                            neg_q <= neg_res;
                            count <= '0;
                            if (special) begin
                                result_q <= special_val;
                                done_q   <= 1'b1;
                                state    <= ST_DONE;
                            end else begin
                                state <= bus.funct3[2] ? ST_DIV : ST_MUL;
                            end
                        end
                    end
                    ST_MUL, ST_DIV: begin
                        if (last_step) begin
                            result_q <= final_val;
                            done_q   <= 1'b1;
                            count    <= '0;
                            state    <= ST_DONE;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Stall is combinational so the pipeline freezes in the accept cycle
    // itself; a flush releases it immediately.
    assign bus.stall  = !bus.flush &&
                        (((state == ST_IDLE) && bus.start) ||
                         (state == ST_MUL) || (state == ST_DIV));
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Self-checking bench for ex_muldiv_ctrl: directed RV32M vectors with
// hand-computed results, latency/stall checks, special cases, flush and
// asynchronous reset in the middle of an operation.
// No ports.
module tb_ex_muldiv_ctrl;
    import riscv_pkg::*;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    logic [31:0] last_result;

    ex_muldiv_ctrl_if #(.XLEN(32)) bus ();

    ex_muldiv_ctrl #(
        .XLEN  (32),
        .CNT_W (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one instruction the way EX would: start held while stalled and
    // through the done cycle, dropped on the cycle after. Measures the cycle of
    // the done pulse relative to accept, stalled cycles in between, and the
    // handshake values around done. lat stays 0 if done never arrives.
    task automatic apply_stimulus(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b, output int lat,
                                  output int stalls, output logic [31:0] res,
                                  output logic stall_acc, output logic stall_done,
                                  output logic done_after);
        bit seen;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        #1 stall_acc = bus.stall;
        lat        = 0;
        stalls     = 0;
        seen       = 1'b0;
        res        = '0;
        stall_done = 1'b1;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            #1;
            if (bus.done === 1'b1) begin
                seen       = 1'b1;
                lat        = k;
                res        = bus.result;
                stall_done = bus.stall;
            end else if (bus.stall === 1'b1) begin
                stalls++;
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        #1 done_after = bus.done;
    endtask

    // Reset state with no instruction present.
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (bus.stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_stall: got %b, expected 0", bus.stall);
        end
        vectors++;
        if (bus.done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_done: got %b, expected 0", bus.done);
        end
        vectors++;
        if (bus.result !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_result: got %h, expected 00000000", bus.result);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Iterative multiply and divide vectors: result, 33-cycle latency,
    // 32 stalled cycles after accept, stall at accept, no stall in DONE even
    // with start high, and a single-cycle done pulse.
    task automatic test_iterative();
        logic [2:0]  f3s  [8] = '{F3_MUL, F3_MULH, F3_MULHU, F3_MULHSU,
                                  F3_DIV, F3_REM, F3_DIVU, F3_REMU};
        logic [31:0] as   [8] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
        logic [31:0] bs   [8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exps [8] = '{32'hFFFFFFEB, 32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF,
                                  32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
        string       names[8] = '{"MUL", "MULH", "MULHU", "MULHSU",
                                  "DIV", "REM", "DIVU", "REMU"};
        int lat, stalls;
        logic [31:0] res;
        logic sa, sd, da;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(f3s[i], as[i], bs[i], lat, stalls, res, sa, sd, da);
            vectors++;
            if (res !== exps[i]) begin
                miscompares++;
                $display("[TB] FAIL %s_result: got %h, expected %h", names[i], res, exps[i]);
            end
            vectors++;
            if (lat !== 33) begin
                miscompares++;
                $display("[TB] FAIL %s_latency: got %0d, expected 33", names[i], lat);
            end
            vectors++;
            if (stalls !== 32) begin
                miscompares++;
                $display("[TB] FAIL %s_stalls: got %0d, expected 32", names[i], stalls);
            end
            vectors++;
            if ({sa, sd, da} !== 3'b100) begin
                miscompares++;
                $display("[TB] FAIL %s_handshake: got stall_acc/stall_done/done_after=%b, expected 100",
                         names[i], {sa, sd, da});
            end
            last_result = exps[i];
        end
    endtask

    // Divide-by-zero and signed overflow: done one cycle after accept, no
    // stall after the accept cycle.
    task automatic test_special();
        logic [2:0]  f3s  [6] = '{F3_DIV, F3_REM, F3_DIV, F3_REM, F3_DIVU, F3_REMU};
        logic [31:0] as   [6] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd9, 32'd9};
        logic [31:0] bs   [6] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
        logic [31:0] exps [6] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0,
                                  32'hFFFFFFFF, 32'd9};
        string       names[6] = '{"DIV_by0", "REM_by0", "DIV_ovf", "REM_ovf",
                                  "DIVU_by0", "REMU_by0"};
        int lat, stalls;
        logic [31:0] res;
        logic sa, sd, da;
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(f3s[i], as[i], bs[i], lat, stalls, res, sa, sd, da);
            vectors++;
            if (res !== exps[i]) begin
                miscompares++;
                $display("[TB] FAIL %s_result: got %h, expected %h", names[i], res, exps[i]);
            end
            vectors++;
            if (lat !== 1) begin
                miscompares++;
                $display("[TB] FAIL %s_latency: got %0d, expected 1", names[i], lat);
            end
            vectors++;
            if ({sa, sd, da} !== 3'b100) begin
                miscompares++;
                $display("[TB] FAIL %s_handshake: got stall_acc/stall_done/done_after=%b, expected 100",
                         names[i], {sa, sd, da});
            end
            last_result = exps[i];
        end
    endtask

    // Flush at T+10 of a DIVU: stall drops that cycle, no done, result keeps
    // its old value, and a fresh start at T+12 runs normally.
    task automatic test_flush();
        int lat, stalls;
        logic [31:0] res;
        logic sa, sd, da;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = F3_DIVU;
        bus.op_a   = 32'd100;
        bus.op_b   = 32'd7;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.flush = 1'b1;
        #1;
        vectors++;
        if (bus.stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_stall: got %b, expected 0", bus.stall);
        end
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        vectors++;
        if ({bus.done, bus.stall} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL flush_idle: got done/stall=%b, expected 00", {bus.done, bus.stall});
        end
        vectors++;
        if (bus.result !== last_result) begin
            miscompares++;
            $display("[TB] FAIL flush_result_held: got %h, expected %h", bus.result, last_result);
        end
        apply_stimulus(F3_DIVU, 32'd100, 32'd7, lat, stalls, res, sa, sd, da);
        vectors++;
        if (res !== 32'd14 || lat !== 33) begin
            miscompares++;
            $display("[TB] FAIL flush_restart: got result %h latency %0d, expected 0000000e latency 33",
                     res, lat);
        end
        last_result = 32'd14;
    endtask

    // start together with flush in IDLE must not be accepted.
    task automatic test_flush_start_idle();
        int dones;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.flush  = 1'b1;
        bus.funct3 = F3_MUL;
        bus.op_a   = 32'd3;
        bus.op_b   = 32'd4;
        #1;
        vectors++;
        if (bus.stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_start_stall: got %b, expected 0", bus.stall);
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (bus.done === 1'b1 || bus.stall === 1'b1) dones++;
        end
        vectors++;
        if (dones !== 0 || bus.result !== last_result) begin
            miscompares++;
            $display("[TB] FAIL flush_start_no_accept: got %0d busy cycles result %h, expected 0 and %h",
                     dones, bus.result, last_result);
        end
    endtask

    // Reset asserted at T+5 of a MUL clears outputs at once; afterwards a
    // normal MUL completes and start held through DONE is not re-accepted.
    task automatic test_reset_mid();
        int lat, stalls, busy;
        logic [31:0] res;
        logic sa, sd, da;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = F3_MUL;
        bus.op_a   = 32'd7;
        bus.op_b   = 32'hFFFFFFFD;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
        end
        #2;
        reset     = 1'b1;
        bus.start = 1'b0;
        #1;
        vectors++;
        if ({bus.stall, bus.done} !== 2'b00 || bus.result !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid: got stall/done=%b result %h, expected 00 and 00000000",
                     {bus.stall, bus.done}, bus.result);
        end
        @(negedge clk);
        reset = 1'b0;
        apply_stimulus(F3_MUL, 32'd7, 32'hFFFFFFFD, lat, stalls, res, sa, sd, da);
        vectors++;
        if (res !== 32'hFFFFFFEB || lat !== 33 || {sa, sd, da} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL reset_recover: got result %h latency %0d handshake %b, expected ffffffeb 33 100",
                     res, lat, {sa, sd, da});
        end
        busy = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (bus.done === 1'b1 || bus.stall === 1'b1) busy++;
        end
        vectors++;
        if (busy !== 0) begin
            miscompares++;
            $display("[TB] FAIL no_reaccept: got %0d busy cycles, expected 0", busy);
        end
    endtask

    // Test sequence.
    initial begin
        vectors     = 0;
        miscompares = 0;
        last_result = 32'h0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.flush   = 1'b0;
        bus.funct3  = 3'b000;
        bus.op_a    = 32'h0;
        bus.op_b    = 32'h0;
        test_reset();
        test_iterative();
        test_special();
        test_flush();
        test_flush_start_idle();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
